// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request in flight
// and buffers returned words in an in-order queue for decode. Optional FETCH_BYPASS_EN.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  // state  | meaning
  // S_REQ  | may issue a request when a queue slot is free
  // S_WAIT | one request granted, response will be queued
  // S_DROP | one request granted before a redirect, response is discarded
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic [31:0]   q_inst [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic        outstanding;
  logic        free_slot;
  logic        q_empty;
  logic        rsp_take;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] redirect_tgt;

  assign outstanding  = (state != S_REQ);
  assign free_slot    = (int'(count) + int'(outstanding)) < QDEPTH;
  assign q_empty      = (count == '0);
  assign redirect_tgt = redirect_pc & ~32'h0000_0003;

  assign imem_req  = (state == S_REQ) && free_slot && !redirect && !rst;
  assign imem_addr = fetch_pc;

  assign rsp_take = (state == S_WAIT) && imem_rvalid && !redirect;

`ifdef FETCH_BYPASS_EN
  // Hand the response straight to decode when nothing is queued ahead of it.
  assign bypass = q_empty && rsp_take;
  assign push   = rsp_take && !(bypass && id_ready);
`else
  assign bypass = 1'b0;
  assign push   = rsp_take;
`endif

  assign pop      = !q_empty && id_ready && !redirect;
  assign id_valid = !q_empty || bypass;

  always_comb begin
    id_inst = NOP;
    id_pc   = 32'h0000_0000;
    if (bypass) begin
      id_inst = imem_rdata;
      id_pc   = pend_pc;
    end else if (!q_empty) begin
      id_inst = q_inst[head];
      id_pc   = q_pc[head];
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[tail] <= imem_rdata;
      q_pc[tail]   <= pend_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      pend_pc  <= 32'h0000_0000;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_tgt;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      case (state)
        S_REQ:   state <= S_REQ;
        S_WAIT:  state <= imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state <= imem_rvalid ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req && imem_gnt) begin
            pend_pc  <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT:  if (imem_rvalid) state <= S_REQ;
        S_DROP:  if (imem_rvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase

      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
